gain_tracker: RTL and testbench
===============================

# gain_tracker

Envelope-driven gain generator that produces the signed multiplier word consumed by the attenuator stage. It watches the same sample stream, compares each sample's magnitude against a threshold, and ramps the gain down (attack), holds, then ramps it back to full scale (release). Output is a registered Q1.(MULT_W-1) multiplier updated once per input sample, which makes it a simple compressor/limiter control path.

## Interface
- DWIDTH, 16, sample width (signed two's complement)
- MULT_W, 9, multiplier width (signed); full scale FULL = 2^(MULT_W-1)-1
- MIN_GAIN, 32, lowest gain the attack ramp may reach; legal range 1..FULL
- ATTACK_DIV, 4, over-threshold samples per gain decrement (≥1)
- RELEASE_DIV, 256, under-threshold samples per gain increment (≥1)
- HOLD_SAMPLES, 1024, under-threshold samples held before release starts (≥1)

- clk_i  in  1  system clock
- srst_i  in  1  synchronous reset, active-high
- sample_valid_i  in  1  qualifies data_signed_i; one sample per high cycle
- data_signed_i  in  DWIDTH  signed audio sample
- threshold_i  in  DWIDTH-1  unsigned magnitude threshold
- bypass_i  in  1  force full-scale gain and clear all state
- mult_o  out  MULT_W  signed gain word for the attenuator, range MIN_GAIN..FULL
- mult_valid_o  out  1  one-cycle pulse: mult_o updated for the previous sample
- gain_reduction_o  out  1  high while mult_o != FULL

## Operation
- Magnitude mag = |data_signed_i|, DWIDTH-1 bits unsigned; most negative input saturates to 2^(DWIDTH-1)-1. over = mag > threshold_i (strict).
- States: IDLE, ATTACK, HOLD, RELEASE. Registers: gain (MULT_W), atk_cnt, hold_cnt, rel_cnt. All counters and the state advance only on cycles with sample_valid_i high.
- Any sample with over (any state): state←ATTACK; hold_cnt, rel_cnt←0; if atk_cnt==ATTACK_DIV-1 then gain←max(gain-1, MIN_GAIN), atk_cnt←0, else atk_cnt++. atk_cnt is 0 on entry to ATTACK, so the entry sample counts as the first.
- ATTACK, sample not over: state←HOLD, hold_cnt←HOLD_SAMPLES-1, atk_cnt←0.
- HOLD, not over: if hold_cnt==0 then state←RELEASE, rel_cnt←0, else hold_cnt--.
- RELEASE, not over: if rel_cnt==RELEASE_DIV-1 then gain++, rel_cnt←0, and state←IDLE when the new gain == FULL; else rel_cnt++.
- IDLE, not over: no change; gain stays FULL.
- Gain at MIN_GAIN: further attack steps hold it at MIN_GAIN; atk_cnt still wraps.
- bypass_i high: same effect as reset on the next edge (gain←FULL, state IDLE, counters 0). Any sample on that cycle is ignored for tracking; mult_valid_o still pulses.
- mult_o = gain (always positive, MSB 0). gain_reduction_o = registered (gain != FULL).
- threshold_i and bypass_i may change on any cycle. They take effect on the next sample or edge.

## Timing
- Reset values: mult_o = FULL, gain_reduction_o = 0, mult_valid_o = 0, state IDLE, all counters 0.
- Latency 1: a sample accepted at edge N gives updated mult_o and gain_reduction_o after edge N, with mult_valid_o high for that one cycle.
- Back-to-back samples (valid every cycle) are supported. There is no backpressure.
- sample_valid_i low: all registers hold and mult_valid_o = 0.
- srst_i has priority over bypass_i, and bypass_i has priority over sample processing.
- Attack ramp from FULL to MIN_GAIN takes ATTACK_DIV×(FULL-MIN_GAIN) over samples. After the last over sample, the first gain increment lands on under sample 2+HOLD_SAMPLES+RELEASE_DIV-1.

## Test plan
Parameters for all scenarios: ATTACK_DIV=4, RELEASE_DIV=8, HOLD_SAMPLES=16, MIN_GAIN=32, threshold_i=1000.
- Reset with srst_i high for 3 cycles -> mult_o=255, gain_reduction_o=0, mult_valid_o=0. Then one sample of 1000 -> mult_valid_o pulses, mult_o stays 255 (not strictly over).
- 8 consecutive samples of +2000 -> mult_o=254 after the 4th sample and 253 after the 8th. gain_reduction_o goes high with the 4th.
- Follow with samples of 0 -> mult_o holds 253 through under sample 24, reads 254 after under sample 25, and reads 255 after under sample 33 with gain_reduction_o=0 and state IDLE.
- Sustained -32768 with threshold_i=32766 -> counted as over (saturated mag 32767). mult_o reaches 32 after 892 samples and stays 32 for 100 more.
- Gain at 200 in ATTACK, assert bypass_i together with sample_valid_i and +5000 -> next cycle mult_o=255, gain_reduction_o=0, mult_valid_o=1. The following under sample leaves the state IDLE.
- Interleave sample_valid_i low for 100 cycles in the middle of HOLD and of RELEASE -> no counter or gain change and mult_valid_o=0 throughout. Timing then resumes exactly as in the contiguous case.

Source files
------------

// File: rtl/gain_tracker_if.sv
// -----------------------------------------------------------------------------
// gain_tracker_if
// Groups the sample-side inputs and gain-side outputs of gain_tracker so the
// block and its environment share one bundle.
//   sample_valid_i   : qualifies data_signed_i, one sample per high cycle
//   data_signed_i    : signed audio sample (DWIDTH bits)
//   threshold_i      : unsigned magnitude threshold (DWIDTH-1 bits)
//   bypass_i         : forces full-scale gain and clears tracking state
//   mult_o           : signed Q1.(MULT_W-1) gain word for the attenuator
//   mult_valid_o     : one-cycle pulse, mult_o updated for the previous sample
//   gain_reduction_o : high while mult_o is below full scale
// master drives the sample side, slave is the gain_tracker itself.
// -----------------------------------------------------------------------------
interface gain_tracker_if #(
    parameter int DWIDTH = 16,
    parameter int MULT_W = 9
);
    logic                     sample_valid_i;
    logic signed [DWIDTH-1:0] data_signed_i;
    logic        [DWIDTH-2:0] threshold_i;
    logic                     bypass_i;
    logic signed [MULT_W-1:0] mult_o;
    logic                     mult_valid_o;
    logic                     gain_reduction_o;

    modport master (
        output sample_valid_i,
        output data_signed_i,
        output threshold_i,
        output bypass_i,
        input  mult_o,
        input  mult_valid_o,
        input  gain_reduction_o
    );

    modport slave (
        input  sample_valid_i,
        input  data_signed_i,
        input  threshold_i,
        input  bypass_i,
        output mult_o,
        output mult_valid_o,
        output gain_reduction_o
    );
endinterface

// File: rtl/gain_tracker.sv
// -----------------------------------------------------------------------------
// gain_tracker
// Envelope-driven gain generator for a compressor/limiter. Each qualified
// sample's magnitude is compared with a threshold; over-threshold samples ramp
// the gain down (attack), then after the signal drops the gain is held and
// finally ramped back up to full scale (release).
//   clk_i   : system clock
//   srst_i  : synchronous reset, active-high
//   bus     : gain_tracker_if.slave carrying the sample stream, threshold,
//             bypass and the registered gain outputs
// -----------------------------------------------------------------------------
module gain_tracker #(
    parameter int DWIDTH       = 16,
    parameter int MULT_W       = 9,
    parameter int MIN_GAIN     = 32,
    parameter int ATTACK_DIV   = 4,
    parameter int RELEASE_DIV  = 256,
    parameter int HOLD_SAMPLES = 1024
) (
    input  logic           clk_i,
    input  logic           srst_i,
    gain_tracker_if.slave  bus
);

    localparam int FULL_INT = (1 << (MULT_W - 1)) - 1;
    localparam logic [MULT_W-1:0] FULL    = MULT_W'(FULL_INT);
    localparam logic [MULT_W-1:0] FULL_M1 = MULT_W'(FULL_INT - 1);
    localparam logic [MULT_W-1:0] MIN     = MULT_W'(MIN_GAIN);

    localparam int ATK_W  = (ATTACK_DIV   > 1) ? $clog2(ATTACK_DIV)   : 1;
    localparam int REL_W  = (RELEASE_DIV  > 1) ? $clog2(RELEASE_DIV)  : 1;
    localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [ATK_W-1:0]  ATK_LAST  = ATK_W'(ATTACK_DIV - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        HOLD,
        RELEASE
    } state_t;

    state_t            r_state;
    logic [MULT_W-1:0] r_gain;
    logic [ATK_W-1:0]  r_atkCnt;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [REL_W-1:0]  r_relCnt;
    logic              r_multValid;
    logic              r_gainRed;

    state_t            w_stateNext;
    logic [MULT_W-1:0] w_gainNext;
    logic [ATK_W-1:0]  w_atkNext;
    logic [HOLD_W-1:0] w_holdNext;
    logic [REL_W-1:0]  w_relNext;

    logic [DWIDTH-1:0] w_negData;
    logic [DWIDTH-2:0] w_mag;
    logic              w_over;

    // Sample magnitude. The most negative code has no positive counterpart in
    // DWIDTH-1 bits, so it saturates to the largest representable magnitude.
    always_comb begin
        w_negData = -bus.data_signed_i;
        w_mag     = bus.data_signed_i[DWIDTH-2:0];
        if (bus.data_signed_i[DWIDTH-1]) begin
            if (w_negData[DWIDTH-1]) begin
                w_mag = '1;
            end else begin
                w_mag = w_negData[DWIDTH-2:0];
            end
        end
        w_over = (w_mag > bus.threshold_i);
    end

    // Next-state logic. Nothing moves unless a sample is qualified. An over
    // sample always drives the attack ramp regardless of state; otherwise the
    // current state decides how the hold and release counters advance. The
    // release step saturates at full scale so a release entered without any
    // prior decrement cannot overflow the gain.
    always_comb begin
        w_stateNext = r_state;
        w_gainNext  = r_gain;
        w_atkNext   = r_atkCnt;
        w_holdNext  = r_holdCnt;
        w_relNext   = r_relCnt;
        if (bus.sample_valid_i) begin
            if (w_over) begin
                w_stateNext = ATTACK;
                w_holdNext  = '0;
                w_relNext   = '0;
                if (r_atkCnt == ATK_LAST) begin
                    w_atkNext  = '0;
                    w_gainNext = (r_gain > MIN) ? (r_gain - MULT_W'(1)) : MIN;
                end else begin
                    w_atkNext = r_atkCnt + ATK_W'(1);
                end
            end else begin
                case (r_state)
                    ATTACK: begin
                        w_stateNext = HOLD;
                        w_holdNext  = HOLD_LAST;
                        w_atkNext   = '0;
                    end
                    HOLD: begin
                        if (r_holdCnt == '0) begin
                            w_stateNext = RELEASE;
                            w_relNext   = '0;
                        end else begin
                            w_holdNext = r_holdCnt - HOLD_W'(1);
                        end
                    end
                    RELEASE: begin
                        if (r_relCnt == REL_LAST) begin
                            w_relNext = '0;
                            if (r_gain >= FULL_M1) begin
                                w_gainNext  = FULL;
                                w_stateNext = IDLE;
                            end else begin
                                w_gainNext = r_gain + MULT_W'(1);
                            end
                        end else begin
                            w_relNext = r_relCnt + REL_W'(1);
                        end
                    end
                    default: begin
                        w_stateNext = IDLE;
                    end
                endcase
            end
        end
    end

    // State register. Reset outranks bypass, and bypass outranks tracking;
    // bypass still reports a valid pulse for a sample that arrives with it.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= IDLE;
            r_gain      <= FULL;
            r_atkCnt    <= '0;
            r_holdCnt   <= '0;
            r_relCnt    <= '0;
            r_multValid <= 1'b0;
            r_gainRed   <= 1'b0;
        end else if (bus.bypass_i) begin
            r_state     <= IDLE;
            r_gain      <= FULL;
            r_atkCnt    <= '0;
            r_holdCnt   <= '0;
            r_relCnt    <= '0;
            r_multValid <= bus.sample_valid_i;
            r_gainRed   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_gain      <= w_gainNext;
            r_atkCnt    <= w_atkNext;
            r_holdCnt   <= w_holdNext;
            r_relCnt    <= w_relNext;
            r_multValid <= bus.sample_valid_i;
            r_gainRed   <= (w_gainNext != FULL);
        end
    end

    assign bus.mult_o           = r_gain;
    assign bus.mult_valid_o     = r_multValid;
    assign bus.gain_reduction_o = r_gainRed;

endmodule

// File: tb/tb_gain_tracker.sv
// -----------------------------------------------------------------------------
// tb_gain_tracker
// Directed bench for gain_tracker with ATTACK_DIV=4, RELEASE_DIV=8,
// HOLD_SAMPLES=16, MIN_GAIN=32 (full scale 255). Each scenario task drives
// its own samples and compares the gain outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_gain_tracker;

    localparam int DWIDTH = 16;
    localparam int MULT_W = 9;

    logic clk;
    logic srst;

    int numChecks;
    int numPassed;

    gain_tracker_if #(.DWIDTH(DWIDTH), .MULT_W(MULT_W)) bus ();

    gain_tracker #(
        .DWIDTH       (DWIDTH),
        .MULT_W       (MULT_W),
        .MIN_GAIN     (32),
        .ATTACK_DIV   (4),
        .RELEASE_DIV  (8),
        .HOLD_SAMPLES (16)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Holds reset for the requested number of edges with inputs quiet.
    task automatic doReset(input int cycles);
        @(negedge clk);
        srst                = 1'b1;
        bus.sample_valid_i  = 1'b0;
        bus.bypass_i        = 1'b0;
        bus.data_signed_i   = '0;
        bus.threshold_i     = 15'd1000;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
    endtask

    // Presents one qualified sample and returns 1 unit after the edge that
    // accepts it. Consecutive calls keep sample_valid_i high back-to-back.
    task automatic applyStimulus(input logic signed [DWIDTH-1:0] d);
        @(negedge clk);
        bus.sample_valid_i = 1'b1;
        bus.data_signed_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic dropValid();
        @(negedge clk);
        bus.sample_valid_i = 1'b0;
    endtask

    // Reset state, then a sample exactly at threshold is not counted as over.
    task automatic test_reset();
        doReset(3);
        #1;
        numChecks++;
        if (bus.mult_o !== 9'sd255) $display("[TB] FAIL reset_mult got %0d want 255", bus.mult_o);
        else numPassed++;
        numChecks++;
        if (bus.gain_reduction_o !== 1'b0) $display("[TB] FAIL reset_gr got %b want 0", bus.gain_reduction_o);
        else numPassed++;
        numChecks++;
        if (bus.mult_valid_o !== 1'b0) $display("[TB] FAIL reset_mv got %b want 0", bus.mult_valid_o);
        else numPassed++;
        applyStimulus(16'sd1000);
        numChecks++;
        if (bus.mult_valid_o !== 1'b1) $display("[TB] FAIL eq_thresh_mv got %b want 1", bus.mult_valid_o);
        else numPassed++;
        numChecks++;
        if (bus.mult_o !== 9'sd255) $display("[TB] FAIL eq_thresh_mult got %0d want 255", bus.mult_o);
        else numPassed++;
        dropValid();
        @(posedge clk);
        #1;
        numChecks++;
        if (bus.mult_valid_o !== 1'b0) $display("[TB] FAIL mv_after_gap got %b want 0", bus.mult_valid_o);
        else numPassed++;
    endtask

    // Eight over samples: one decrement every fourth sample.
    task automatic test_attack();
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(16'sd2000);
            if (i == 3) begin
                numChecks++;
                if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0)
                    $display("[TB] FAIL attack_s3 got %0d/%b want 255/0", bus.mult_o, bus.gain_reduction_o);
                else numPassed++;
            end
            if (i == 4) begin
                numChecks++;
                if (bus.mult_o !== 9'sd254 || bus.gain_reduction_o !== 1'b1)
                    $display("[TB] FAIL attack_s4 got %0d/%b want 254/1", bus.mult_o, bus.gain_reduction_o);
                else numPassed++;
            end
            if (i == 8) begin
                numChecks++;
                if (bus.mult_o !== 9'sd253) $display("[TB] FAIL attack_s8 got %0d want 253", bus.mult_o);
                else numPassed++;
            end
        end
    endtask

    // Under samples after the attack: hold 24, first step at 25, full at 33.
    task automatic test_release();
        for (int i = 1; i <= 36; i++) begin
            applyStimulus(16'sd0);
            if (i == 24) begin
                numChecks++;
                if (bus.mult_o !== 9'sd253) $display("[TB] FAIL release_u24 got %0d want 253", bus.mult_o);
                else numPassed++;
            end
            if (i == 25) begin
                numChecks++;
                if (bus.mult_o !== 9'sd254) $display("[TB] FAIL release_u25 got %0d want 254", bus.mult_o);
                else numPassed++;
            end
            if (i == 32) begin
                numChecks++;
                if (bus.mult_o !== 9'sd254) $display("[TB] FAIL release_u32 got %0d want 254", bus.mult_o);
                else numPassed++;
            end
            if (i == 33) begin
                numChecks++;
                if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0)
                    $display("[TB] FAIL release_u33 got %0d/%b want 255/0", bus.mult_o, bus.gain_reduction_o);
                else numPassed++;
            end
            if (i == 36) begin
                numChecks++;
                if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0)
                    $display("[TB] FAIL idle_u36 got %0d/%b want 255/0", bus.mult_o, bus.gain_reduction_o);
                else numPassed++;
            end
        end
        dropValid();
    endtask

    // Most negative sample saturates to 32767 > 32766; floor at MIN_GAIN.
    task automatic test_saturation();
        int badCycles;
        doReset(1);
        bus.threshold_i = 15'd32766;
        for (int i = 1; i <= 892; i++) begin
            applyStimulus(-16'sd32768);
            if (i == 891) begin
                numChecks++;
                if (bus.mult_o !== 9'sd33) $display("[TB] FAIL sat_s891 got %0d want 33", bus.mult_o);
                else numPassed++;
            end
        end
        numChecks++;
        if (bus.mult_o !== 9'sd32) $display("[TB] FAIL sat_s892 got %0d want 32", bus.mult_o);
        else numPassed++;
        badCycles = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(-16'sd32768);
            if (bus.mult_o !== 9'sd32) badCycles++;
        end
        numChecks++;
        if (badCycles !== 0) $display("[TB] FAIL sat_floor bad_samples %0d want 0", badCycles);
        else numPassed++;
        dropValid();
        bus.threshold_i = 15'd1000;
    endtask

    // Bypass in the middle of an attack clears gain and the attack counter.
    task automatic test_bypass();
        doReset(1);
        for (int i = 0; i < 221; i++) applyStimulus(16'sd2000);
        numChecks++;
        if (bus.mult_o !== 9'sd200) $display("[TB] FAIL byp_pre got %0d want 200", bus.mult_o);
        else numPassed++;
        @(negedge clk);
        bus.bypass_i       = 1'b1;
        bus.data_signed_i  = 16'sd5000;
        bus.sample_valid_i = 1'b1;
        @(posedge clk);
        #1;
        numChecks++;
        if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0 || bus.mult_valid_o !== 1'b1)
            $display("[TB] FAIL byp_edge got %0d/%b/%b want 255/0/1", bus.mult_o, bus.gain_reduction_o, bus.mult_valid_o);
        else numPassed++;
        @(negedge clk);
        bus.bypass_i = 1'b0;
        applyStimulus(16'sd0);
        numChecks++;
        if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0)
            $display("[TB] FAIL byp_under got %0d/%b want 255/0", bus.mult_o, bus.gain_reduction_o);
        else numPassed++;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(16'sd2000);
            if (i == 3) begin
                numChecks++;
                if (bus.mult_o !== 9'sd255) $display("[TB] FAIL byp_atk3 got %0d want 255", bus.mult_o);
                else numPassed++;
            end
        end
        numChecks++;
        if (bus.mult_o !== 9'sd254 || bus.gain_reduction_o !== 1'b1)
            $display("[TB] FAIL byp_atk4 got %0d/%b want 254/1", bus.mult_o, bus.gain_reduction_o);
        else numPassed++;
        dropValid();
    endtask

    // 100-cycle valid gaps in HOLD and RELEASE must freeze everything.
    task automatic test_valid_gaps();
        int badCycles;
        doReset(1);
        for (int i = 0; i < 4; i++) applyStimulus(16'sd2000);
        for (int u = 1; u <= 25; u++) begin
            if (u == 9 || u == 21) begin
                badCycles = 0;
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    bus.sample_valid_i = 1'b0;
                    @(posedge clk);
                    #1;
                    if (bus.mult_valid_o !== 1'b0 || bus.mult_o !== 9'sd254 || bus.gain_reduction_o !== 1'b1)
                        badCycles++;
                end
                numChecks++;
                if (badCycles !== 0) $display("[TB] FAIL gap_before_u%0d bad_cycles %0d want 0", u, badCycles);
                else numPassed++;
            end
            applyStimulus(16'sd0);
            if (u == 24) begin
                numChecks++;
                if (bus.mult_o !== 9'sd254) $display("[TB] FAIL gap_u24 got %0d want 254", bus.mult_o);
                else numPassed++;
            end
        end
        numChecks++;
        if (bus.mult_o !== 9'sd255 || bus.gain_reduction_o !== 1'b0)
            $display("[TB] FAIL gap_u25 got %0d/%b want 255/0", bus.mult_o, bus.gain_reduction_o);
        else numPassed++;
        dropValid();
    endtask

    initial begin
        numChecks          = 0;
        numPassed          = 0;
        srst               = 1'b1;
        bus.sample_valid_i = 1'b0;
        bus.bypass_i       = 1'b0;
        bus.data_signed_i  = '0;
        bus.threshold_i    = 15'd1000;
        test_reset();
        test_attack();
        test_release();
        test_saturation();
        test_bypass();
        test_valid_gaps();
        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
